// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared FSM state encoding and default parameter values for
//               the SPI frame arbiter and its SPI control neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Frame sequencing states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_LOAD    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_NEXT    = 3'd5,
    ST_GAP     = 3'd6
  } state_t;

  localparam int c_def_num_req = 3;
  localparam int c_def_clk_div = 6;
  localparam int c_def_ss_gap  = 4;
  localparam int c_len_w       = 4;
  localparam int c_byte_w      = 8;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Searches the request vector starting at
//               the bit after the last winner and returns a one-hot grant.
//               The pointer only moves when the caller accepts the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = spi_pkg::c_def_num_req
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [c_ptr_w-1:0] r_ptr;
  logic [c_ptr_w-1:0] w_win_idx;
  logic               w_found;

  // Cyclic priority search beginning at the pointer position
  always_comb begin
    int                 v_idx;
    logic [c_ptr_w-1:0] v_sel;
    grant     = '0;
    w_win_idx = '0;
    w_found   = 1'b0;
    v_idx     = 0;
    v_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= NUM_REQ) begin
        v_idx = v_idx - NUM_REQ;
      end
      v_sel = c_ptr_w'(v_idx);
      if (!w_found && req[v_sel]) begin
        w_found      = 1'b1;
        grant[v_sel] = 1'b1;
        w_win_idx    = v_sel;
      end
    end
  end

  // Pointer moves to the bit after the accepted winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (en && w_found) begin
      r_ptr <= (w_win_idx == c_ptr_w'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_arbiter
// Description : Arbitrates multi-byte frames from several requesters onto a
//               single SPI master. Owns slave select for the whole frame,
//               feeds bytes one at a time and provides the 2x SCK tick.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = spi_pkg::c_def_num_req,
  parameter int CLK_DIV = spi_pkg::c_def_clk_div,
  parameter int SS_GAP  = spi_pkg::c_def_ss_gap
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [4*NUM_REQ-1:0] req_len_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   byte_rd_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic                 ena_2clk_o,
  output logic                 spi_start_o,
  output logic [7:0]           spi_tx_o,
  input  logic                 spi_busy_i,
  output logic                 spi_ss_n_o
);

  logic [1:0]         r_rst_sync;
  logic               w_run;
  logic [7:0]         r_div;
  logic               r_ena;
  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [3:0]         r_gap;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_byte_rd;
  logic [NUM_REQ-1:0] r_done;
  logic               r_start;
  logic [7:0]         r_tx;
  logic               r_ss_n;
  logic [NUM_REQ-1:0] w_arb_grant;
  logic               w_arb_en;
  logic [3:0]         w_win_len;
  logic [7:0]         w_own_data;

  // Release of reset is re-timed so nothing moves until two edges have passed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run = r_rst_sync[1];

  // Free-running divider producing the 2x SCK tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_ena <= 1'b0;
    end else if (!w_run) begin
      r_div <= '0;
      r_ena <= 1'b0;
    end else if (r_div == 8'(CLK_DIV - 1)) begin
      r_div <= '0;
      r_ena <= 1'b1;
    end else begin
      r_div <= r_div + 8'd1;
      r_ena <= 1'b0;
    end
  end

  // Length of the prospective winner and current byte of the owner
  always_comb begin
    w_win_len  = '0;
    w_own_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_arb_grant[k]) begin
        w_win_len = w_win_len | req_len_i[4*k +: 4];
      end
      if (r_grant[k]) begin
        w_own_data = w_own_data | req_data_i[8*k +: 8];
      end
    end
  end

  assign w_arb_en = (r_state == ST_IDLE) && (|req_i);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~w_run),
    .en    (w_arb_en),
    .req   (req_i),
    .grant (w_arb_grant)
  );

  // Frame sequencer: arbitration, slave select, byte hand-off and SS gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_grant   <= '0;
      r_byte_rd <= '0;
      r_done    <= '0;
      r_start   <= 1'b0;
      r_tx      <= '0;
      r_ss_n    <= 1'b1;
    end else if (!w_run) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_grant   <= '0;
      r_byte_rd <= '0;
      r_done    <= '0;
      r_start   <= 1'b0;
      r_tx      <= '0;
      r_ss_n    <= 1'b1;
    end else begin
      r_start   <= 1'b0;
      r_byte_rd <= '0;
      r_done    <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|req_i) begin
            r_grant <= w_arb_grant;
            r_cnt   <= w_win_len;
            r_state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (r_cnt == 4'd0) begin
            // Empty frame: acknowledge without ever asserting select
            r_done  <= r_grant;
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_ss_n <= 1'b0;
            // Only a tick seen after select is already low counts as setup
            if (r_ena && !r_ss_n) begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          r_tx      <= w_own_data;
          r_start   <= 1'b1;
          r_byte_rd <= r_grant;
          r_state   <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (spi_busy_i) begin
            r_state <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!spi_busy_i) begin
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (r_cnt == 4'd1) begin
            r_cnt   <= '0;
            r_done  <= r_grant;
            r_grant <= '0;
            r_ss_n  <= 1'b1;
            r_gap   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_cnt   <= r_cnt - 4'd1;
            r_state <= ST_LOAD;
          end
        end
        ST_GAP: begin
          if (r_ena) begin
            if (r_gap == 4'(SS_GAP - 1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_gap <= r_gap + 4'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_o     = r_grant;
  assign byte_rd_o   = r_byte_rd;
  assign done_o      = r_done;
  assign ena_2clk_o  = r_ena;
  assign spi_start_o = r_start;
  assign spi_tx_o    = r_tx;
  assign spi_ss_n_o  = r_ss_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_arbiter
// Description : Self-checking bench for spi_frame_arbiter with a behavioural
//               SPI master, requester byte sources and a round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_arbiter;

  localparam int NUM_REQ = 3;
  localparam int CLK_DIV = 6;
  localparam int SS_GAP  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_i;
  logic [4*NUM_REQ-1:0] req_len_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   grant_o, byte_rd_o, done_o;
  logic                 ena_2clk_o, spi_start_o, spi_ss_n_o;
  logic [7:0]           spi_tx_o;
  logic                 spi_busy_i = 1'b0;

  always #5 clk = ~clk;

  spi_frame_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CLK_DIV (CLK_DIV),
    .SS_GAP  (SS_GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .req_len_i   (req_len_i),
    .req_data_i  (req_data_i),
    .grant_o     (grant_o),
    .byte_rd_o   (byte_rd_o),
    .done_o      (done_o),
    .ena_2clk_o  (ena_2clk_o),
    .spi_start_o (spi_start_o),
    .spi_tx_o    (spi_tx_o),
    .spi_busy_i  (spi_busy_i),
    .spi_ss_n_o  (spi_ss_n_o)
  );

  int checks   = 0;
  int failures = 0;

  // Requester byte sources
  logic [7:0] data_mem [NUM_REQ][16];
  logic [3:0] len_mem  [NUM_REQ];
  logic [3:0] rd_idx   [NUM_REQ];

  always_comb begin
    req_len_i  = '0;
    req_data_i = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_len_i[4*k +: 4]  = len_mem[k];
      req_data_i[8*k +: 8] = data_mem[k][rd_idx[k]];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rst_n || done_o[k]) rd_idx[k] <= 4'd0;
      else if (byte_rd_o[k])   rd_idx[k] <= rd_idx[k] + 4'd1;
    end
  end

  // Behavioural SPI master: start -> random delay -> busy for hold cycles
  int busy_dly_max  = 3;
  int busy_hold_min = 1;
  int busy_hold_max = 6;
  int s_st  = 0;
  int s_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      spi_busy_i <= 1'b0;
      s_st       <= 0;
    end else begin
      case (s_st)
        0: if (spi_start_o) begin
             s_cnt <= $urandom_range(busy_dly_max, 0);
             s_st  <= 1;
           end
        1: if (s_cnt == 0) begin
             spi_busy_i <= 1'b1;
             s_cnt      <= $urandom_range(busy_hold_max, busy_hold_min);
             s_st       <= 2;
           end else s_cnt <= s_cnt - 1;
        default: if (s_cnt <= 1) begin
             spi_busy_i <= 1'b0;
             s_st       <= 0;
           end else s_cnt <= s_cnt - 1;
      endcase
    end
  end

  function automatic int idx_of(input logic [NUM_REQ-1:0] v);
    idx_of = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (v[i]) idx_of = i;
  endfunction

  // Activity log and protocol watch
  int         cyc = 0;
  int         n_starts = 0;
  int         start_own [1024];
  logic [7:0] start_tx  [1024];
  int         start_cyc [1024];
  int         n_dones = 0;
  int         done_own [256];
  int         n_ss_edges = 0;
  int         n_falls = 0;
  int         gap_cnt = 0;
  int         gap_log [256];
  logic       ss_prev = 1'b1;
  int         proto_err = 0;
  logic       in_byte = 1'b0;
  logic       seen_busy = 1'b0;
  logic [7:0] tx_hold = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      in_byte   <= 1'b0;
      seen_busy <= 1'b0;
      ss_prev   <= 1'b1;
      gap_cnt   <= 0;
    end else begin
      proto_err <= proto_err
                 + int'($countones(grant_o) > 1)
                 + int'($countones(byte_rd_o) > 1)
                 + int'($countones(done_o) > 1)
                 + int'(spi_start_o && in_byte)
                 + int'(spi_start_o && spi_ss_n_o)
                 + int'(!spi_ss_n_o && (grant_o == '0))
                 + int'(!spi_start_o && in_byte && (spi_tx_o !== tx_hold));
      if (spi_start_o) begin
        start_own[n_starts] <= idx_of(grant_o);
        start_tx[n_starts]  <= spi_tx_o;
        start_cyc[n_starts] <= cyc;
        n_starts            <= n_starts + 1;
        in_byte             <= 1'b1;
        seen_busy           <= 1'b0;
        tx_hold             <= spi_tx_o;
      end else if (in_byte) begin
        if (spi_busy_i) seen_busy <= 1'b1;
        else if (seen_busy) in_byte <= 1'b0;
      end
      if (|done_o) begin
        done_own[n_dones] <= idx_of(done_o);
        n_dones           <= n_dones + 1;
      end
      if (spi_ss_n_o !== ss_prev) n_ss_edges <= n_ss_edges + 1;
      if (spi_ss_n_o && !ss_prev) gap_cnt <= ena_2clk_o ? 1 : 0;
      else if (spi_ss_n_o && ena_2clk_o) gap_cnt <= gap_cnt + 1;
      if (!spi_ss_n_o && ss_prev) begin
        gap_log[n_falls] <= gap_cnt;
        n_falls          <= n_falls + 1;
      end
      ss_prev <= spi_ss_n_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant_o), 0);
    chk({tag, "_byte_rd"}, 32'(byte_rd_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_ss_n"}, 32'(spi_ss_n_o), 1);
    chk({tag, "_start"}, 32'(spi_start_o), 0);
    chk({tag, "_tx"}, 32'(spi_tx_o), 0);
    chk({tag, "_ena"}, 32'(ena_2clk_o), 0);
  endtask

  task automatic fill(input int k, input int len);
    len_mem[k] = 4'(len);
    for (int i = 0; i < 16; i++) data_mem[k][i] = 8'($urandom);
  endtask

  // Round-robin reference: next owner is the first pending requester at or
  // after the slot following the previous owner.
  int m_ptr = 0;

  task automatic run_round(input logic [NUM_REQ-1:0] mask, input logic hold,
                           input int nframes, input string tag);
    int                 exp_own[$];
    logic [NUM_REQ-1:0] pend;
    int                 base_s, base_d, perr0, got, si, exp_starts;
    pend = mask;
    for (int f = 0; f < nframes; f++) begin
      int w = -1;
      for (int i = 0; i < NUM_REQ; i++)
        if (w < 0 && pend[(m_ptr + i) % NUM_REQ]) w = (m_ptr + i) % NUM_REQ;
      exp_own.push_back(w);
      m_ptr = (w + 1) % NUM_REQ;
      if (!hold) pend[w] = 1'b0;
    end
    base_s = n_starts;
    base_d = n_dones;
    perr0  = proto_err;
    got    = 0;
    req_i  = mask;
    for (int c = 0; c < 20000 && got < nframes; c++) begin
      @(negedge clk); #1;
      if (|done_o) begin
        got++;
        if (!hold) req_i = req_i & ~done_o;
        else if (got == nframes) req_i = '0;
      end
    end
    req_i = '0;
    chk({tag, "_frames_done"}, 32'(got), 32'(nframes));
    si = base_s;
    exp_starts = 0;
    for (int f = 0; f < nframes; f++) begin
      int k = exp_own[f];
      chk({tag, "_owner"}, 32'(done_own[base_d + f]), 32'(k));
      for (int b = 0; b < int'(len_mem[k]); b++) begin
        chk({tag, "_start_owner"}, 32'(start_own[si]), 32'(k));
        chk({tag, "_tx"}, 32'(start_tx[si]), 32'(data_mem[k][b]));
        si++;
        exp_starts++;
      end
    end
    chk({tag, "_start_count"}, 32'(n_starts - base_s), 32'(exp_starts));
    chk({tag, "_protocol"}, 32'(proto_err - perr0), 0);
  endtask

  initial begin
    int first_hi, second_hi, base_s, base_d, base_e, base_f, lat;
    logic [NUM_REQ-1:0] mask;
    rst_n = 1'b0;
    req_i = '0;
    for (int k = 0; k < NUM_REQ; k++) fill(k, 1);

    // Reset values and divider start-up
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    first_hi  = 0;
    second_hi = 0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      if (ena_2clk_o) begin
        if (first_hi == 0) first_hi = e;
        else if (second_hi == 0) second_hi = e;
      end
    end
    chk("ena_first_pulse_edge", 32'(first_hi), 8);
    chk("ena_period", 32'(second_hi - first_hi), CLK_DIV);
    @(negedge clk);

    // Contention: all requesters held, one byte each
    for (int k = 0; k < NUM_REQ; k++) fill(k, 1);
    base_f = n_falls;
    run_round(3'b111, 1'b1, 4, "contention");
    for (int j = 1; j <= 3; j++)
      chk("contention_ss_gap_ticks", 32'(gap_log[base_f + j]), SS_GAP);

    // Single three-byte frame
    fill(0, 3);
    data_mem[0][0] = 8'hA5;
    data_mem[0][1] = 8'h5A;
    data_mem[0][2] = 8'hFF;
    base_e = n_ss_edges;
    run_round(3'b001, 1'b0, 1, "single");
    chk("single_ss_edges", 32'(n_ss_edges - base_e), 2);
    chk("single_ss_high_after", 32'(spi_ss_n_o), 1);

    // Zero-length frame
    repeat (40) @(negedge clk);
    fill(1, 0);
    base_s = n_starts;
    base_e = n_ss_edges;
    lat = 99;
    #1 req_i = 3'b010;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); #1;
      if (done_o[1]) begin
        lat = c;
        break;
      end
    end
    req_i = '0;
    m_ptr = 2;
    chk("zero_len_done_within_3", 32'(lat <= 3), 1);
    chk("zero_len_no_start", 32'(n_starts - base_s), 0);
    chk("zero_len_ss_untouched", 32'(n_ss_edges - base_e), 0);

    // Randomised rounds
    for (int r = 0; r < 6; r++) begin
      busy_dly_max  = $urandom_range(3, 0);
      busy_hold_max = $urandom_range(8, 1);
      mask = NUM_REQ'($urandom_range(7, 1));
      for (int k = 0; k < NUM_REQ; k++) fill(k, $urandom_range(4, 0));
      run_round(mask, 1'b0, $countones(mask), "random");
    end

    // Slow master holding busy for 40 cycles per byte
    busy_dly_max  = 1;
    busy_hold_min = 40;
    busy_hold_max = 40;
    fill(0, 2);
    base_s = n_starts;
    run_round(3'b001, 1'b0, 1, "slow");
    chk("slow_start_spacing", 32'(start_cyc[base_s + 1] - start_cyc[base_s] >= 41), 1);

    // Reset during WAIT_LO of byte 2 of a 4-byte frame from requester 1
    busy_dly_max  = 0;
    busy_hold_min = 6;
    busy_hold_max = 6;
    fill(1, 4);
    base_s = n_starts;
    base_d = n_dones;
    req_i  = 3'b010;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (n_starts - base_s >= 2 && spi_busy_i) break;
    end
    @(negedge clk);
    rst_n = 1'b0;
    req_i = '0;
    #1;
    chk_reset_vals("midreset");
    chk("midreset_second_byte_reached", 32'(n_starts - base_s), 2);
    repeat (3) @(negedge clk);
    chk("midreset_no_done", 32'(n_dones - base_d), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    m_ptr = 0;
    busy_hold_min = 1;
    busy_hold_max = 4;
    fill(0, 1);
    fill(2, 1);
    run_round(3'b101, 1'b0, 2, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
